// File: rtl/conv_ch_scheduler_if.sv
// Bundle between the layer controller / datapath side and conv_ch_scheduler.
// Widths follow the same parameters as the scheduler so both ends agree.
interface conv_ch_scheduler_if #(
  parameter int data_width = 16,
  parameter int w_width    = 16,
  parameter int map_width  = 28,
  parameter int out_ch     = 16
);
  localparam int chw = (out_ch > 1) ? $clog2(out_ch) : 1;
  localparam int rcw = $clog2(map_width - 4);
  localparam int kw  = w_width + data_width + 6;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [chw-1:0]        w_sel;
  logic                  w_load;
  logic                  stream_start;
  logic                  k_valid;
  logic [kw-1:0]         k_data;
  logic                  res_valid;
  logic [data_width-1:0] res_data;
  logic [chw-1:0]        res_ch;
  logic [rcw-1:0]        res_row;
  logic [rcw-1:0]        res_col;
  logic                  err_overrun;

  modport master (
    output start, k_valid, k_data,
    input  busy, done, w_sel, w_load, stream_start,
           res_valid, res_data, res_ch, res_row, res_col, err_overrun
  );

  modport slave (
    input  start, k_valid, k_data,
    output busy, done, w_sel, w_load, stream_start,
           res_valid, res_data, res_ch, res_row, res_col, err_overrun
  );
endinterface

// File: rtl/conv_ch_scheduler.sv
// Sequences a shared 4-in 5x5 conv datapath over out_ch output channels and
// requantises/tags its outputs. Optional CONV_SCHED_RELU_EN clamps results to >= 0.
module conv_ch_scheduler #(
  parameter int data_width  = 16,
  parameter int w_width     = 16,
  parameter int map_width   = 28,
  parameter int out_ch      = 16,
  parameter int frac_shift  = 15,
  parameter int load_cycles = 2
) (
  input logic               clk,
  input logic               rst_n,
  conv_ch_scheduler_if.slave bus
);
  localparam int kw   = w_width + data_width + 6;
  localparam int chw  = (out_ch > 1) ? $clog2(out_ch) : 1;
  localparam int rcw  = $clog2(map_width - 4);
  localparam int lcw  = $clog2(load_cycles + 1);
  localparam int side = map_width - 4;

  localparam logic signed [kw-1:0] sat_max = {{(kw-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [kw-1:0] sat_min = {{(kw-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, KICK, STREAM, NEXT, FIN} state_t;

  state_t                state, nstate;
  logic [chw-1:0]        w_sel;
  logic [lcw-1:0]        lcnt;
  logic [rcw-1:0]        row, col;
  logic                  accept, last_beat;
  logic signed [kw-1:0]  shifted;
  logic [data_width-1:0] sat;

  assign accept    = bus.k_valid && (state == STREAM);
  assign last_beat = (row == rcw'(side - 1)) && (col == rcw'(side - 1));
  assign shifted   = $signed(bus.k_data) >>> frac_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate           = state;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    bus.w_load       = 1'b0;
    bus.stream_start = 1'b0;
    case (state)
      IDLE:   if (bus.start) nstate = LOAD;
      LOAD: begin
        bus.busy   = 1'b1;
        bus.w_load = 1'b1;
        if (lcnt == lcw'(load_cycles - 1)) nstate = KICK;
      end
      KICK: begin
        bus.busy         = 1'b1;
        bus.stream_start = 1'b1;
        nstate           = STREAM;
      end
      STREAM: begin
        bus.busy = 1'b1;
        if (accept && last_beat) nstate = NEXT;
      end
      NEXT: begin
        bus.busy = 1'b1;
        nstate   = (w_sel == chw'(out_ch - 1)) ? FIN : LOAD;
      end
      FIN: begin
        bus.done = 1'b1;
        nstate   = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  assign bus.w_sel = w_sel;

  // Requantise: arithmetic shift, then clamp to the signed data_width range
  always_comb begin
    if (shifted > sat_max)      sat = {1'b0, {(data_width-1){1'b1}}};
    else if (shifted < sat_min) sat = {1'b1, {(data_width-1){1'b0}}};
    else                        sat = shifted[data_width-1:0];
`ifdef CONV_SCHED_RELU_EN
    if (sat[data_width-1]) sat = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_sel           <= '0;
      lcnt            <= '0;
      row             <= '0;
      col             <= '0;
      bus.err_overrun <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_ch      <= '0;
      bus.res_row     <= '0;
      bus.res_col     <= '0;
    end else begin
      lcnt <= (state == LOAD) ? lcnt + 1'b1 : '0;
      if (state == NEXT && nstate == LOAD) w_sel <= w_sel + 1'b1;
      else if (state == FIN)               w_sel <= '0;
      if (state == KICK) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == rcw'(side - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (bus.k_valid && state != STREAM) bus.err_overrun <= 1'b1;
      // Tags come from the pre-increment counters so they name this beat
      bus.res_valid <= accept;
      if (accept) begin
        bus.res_data <= sat;
        bus.res_ch   <= w_sel;
        bus.res_row  <= row;
        bus.res_col  <= col;
      end
    end
  end
endmodule

// File: tb/tb_conv_ch_scheduler.sv
// Scoreboard bench for conv_ch_scheduler: driver pushes expected results,
// an independent negedge monitor pops and compares on every res_valid.
module tb_conv_ch_scheduler;
  localparam int DW = 16, WW = 16, MW = 28, OC = 16, KW = 38;
  localparam int SIDE = MW - 4, BEATS = SIDE * SIDE;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  ch;
    logic [4:0]  row;
    logic [4:0]  col;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_ch_scheduler_if #(.data_width(DW), .w_width(WW), .map_width(MW), .out_ch(OC)) bus();

  conv_ch_scheduler #(
    .data_width(DW), .w_width(WW), .map_width(MW), .out_ch(OC),
    .frac_shift(15), .load_cycles(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Hand-computed requantisation vectors (frac_shift=15, 16-bit saturation)
  logic signed [KW-1:0] kd [12] = '{
    38'sd98304, -38'sd163840, 38'sd2147483648, -38'sd2147483648,
    38'sd1073709056, 38'sd1073741824, -38'sd1073741824, -38'sd1073774592,
    38'sd245759, -38'sd1, 38'sd137438953471, 38'sd0
  };
  logic signed [15:0] ex [12] = '{
    16'sd3, -16'sd5, 16'sd32767, -16'sd32768,
    16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768,
    16'sd7, -16'sd1, 16'sd32767, 16'sd0
  };

  exp_t sb[$];
  int nvec = 0, nerr = 0;
  int ss_cnt, done_cnt, res_total, busy_cyc;
  int ch_cnt [16];
  logic prev_rv = 1'b0;

  function automatic logic [15:0] expd(input int i);
    logic signed [15:0] r;
    r = ex[i];
`ifdef CONV_SCHED_RELU_EN
    if (r < 0) r = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic clr_counts();
    ss_cnt = 0; done_cnt = 0; res_total = 0; busy_cyc = 0;
    for (int i = 0; i < 16; i++) ch_cnt[i] = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.res_valid) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL res_unexpected: got data=%0d ch=%0d row=%0d col=%0d want no beat",
                 $signed(bus.res_data), bus.res_ch, bus.res_row, bus.res_col);
      end else begin
        e = sb.pop_front();
        if (bus.res_data !== e.d || bus.res_ch !== e.ch ||
            bus.res_row !== e.row || bus.res_col !== e.col) begin
          nerr++;
          $display("FAIL res_beat: got d=%0d ch=%0d r=%0d c=%0d want d=%0d ch=%0d r=%0d c=%0d",
                   $signed(bus.res_data), bus.res_ch, bus.res_row, bus.res_col,
                   $signed(e.d), e.ch, e.row, e.col);
        end
      end
      ch_cnt[bus.res_ch]++;
      res_total++;
    end
    if (bus.stream_start) ss_cnt++;
    if (bus.busy) busy_cyc++;
    if (bus.done) begin
      done_cnt++;
      nvec++;
      if (!prev_rv || sb.size() != 0 || bus.busy) begin
        nerr++;
        $display("FAIL done_timing: got prev_rv=%0d pending=%0d busy=%0d want 1 0 0",
                 prev_rv, sb.size(), bus.busy);
      end
    end
    prev_rv = bus.res_valid;
  end

  task automatic wait_hi(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && bus.stream_start) || (which == 1 && bus.w_load) ||
          (which == 2 && bus.done)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    nvec++; nerr++;
    $display("FAIL wait_timeout: got no event %0d within %0d cycles want event", which, budget);
  endtask

  task automatic run_pass(input int gap_max, input bit dbl_start, input int poke_ch,
                          input int abort_ch);
    bit ok;
    int g, idx;
    exp_t e;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int ch = 0; ch < OC; ch++) begin
      if (ch == poke_ch) begin
        wait_hi(1, 20, ok);
        if (!ok) return;
        bus.k_valid = 1'b1;
        bus.k_data  = kd[0];
        @(negedge clk);
        bus.k_valid = 1'b0;
        chk("overrun_set", bus.err_overrun, 1);
      end
      wait_hi(0, 20, ok);
      if (!ok) return;
      @(negedge clk);
      for (int b = 0; b < BEATS; b++) begin
        if (ch == abort_ch && b == 100) begin
          rst_n = 1'b0;
          bus.k_valid = 1'b0;
          #1;
          chk("rst_busy", bus.busy, 0);
          chk("rst_w_sel", bus.w_sel, 0);
          chk("rst_w_load", bus.w_load, 0);
          chk("rst_stream_start", bus.stream_start, 0);
          chk("rst_res_valid", bus.res_valid, 0);
          chk("rst_res_data", bus.res_data, 0);
          chk("rst_res_row", bus.res_row, 0);
          chk("rst_err_overrun", bus.err_overrun, 0);
          sb.delete();
          return;
        end
        if (gap_max > 0) begin
          g = $urandom_range(gap_max, 0);
          bus.k_valid = 1'b0;
          repeat (g) @(negedge clk);
        end
        idx = (ch * 7 + b) % 12;
        e.d = expd(idx); e.ch = 4'(ch); e.row = 5'(b / SIDE); e.col = 5'(b % SIDE);
        sb.push_back(e);
        bus.k_data  = kd[idx];
        bus.k_valid = 1'b1;
        if (dbl_start && ch == 1 && b == 10) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      bus.k_valid = 1'b0;
    end
    wait_hi(2, 20, ok);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.k_valid = 1'b0; bus.k_data = '0;
    clr_counts();
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_w_sel", bus.w_sel, 0);
    chk("reset_res_valid", bus.res_valid, 0);
    chk("reset_err", bus.err_overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous k_valid, full pass
    run_pass(0, 1'b0, -1, -1);
    repeat (3) @(negedge clk);
    chk("a_stream_starts", ss_cnt, 16);
    chk("a_res_total", res_total, 16 * BEATS);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_busy_after", bus.busy, 0);
    chk("a_busy_cycles", busy_cyc, 16 * (2 + 2 + BEATS));
    chk("a_err", bus.err_overrun, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("a_ch%0d_beats", i), ch_cnt[i], BEATS);

    // Random gaps plus an ignored second start
    clr_counts();
    run_pass(3, 1'b1, -1, -1);
    repeat (10) @(negedge clk);
    chk("b_stream_starts", ss_cnt, 16);
    chk("b_res_total", res_total, 16 * BEATS);
    chk("b_done_cnt", done_cnt, 1);
    chk("b_busy_after", bus.busy, 0);
    chk("b_ch0_beats", ch_cnt[0], BEATS);

    // Overrun in LOAD, then reset mid-STREAM of channel 5
    clr_counts();
    run_pass(0, 1'b0, 2, 5);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("c_idle_busy", bus.busy, 0);
    chk("c_idle_w_sel", bus.w_sel, 0);
    chk("c_idle_w_load", bus.w_load, 0);
    chk("c_done_cnt", done_cnt, 0);

    // Restart from channel 0 with an overrun poke; pass must still complete
    clr_counts();
    run_pass(0, 1'b0, 2, -1);
    repeat (3) @(negedge clk);
    chk("d_stream_starts", ss_cnt, 16);
    chk("d_res_total", res_total, 16 * BEATS);
    chk("d_done_cnt", done_cnt, 1);
    chk("d_err_sticky", bus.err_overrun, 1);
    chk("d_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
